reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- General-purpose register file for the KGP mini-RISC datapath.
- 64 x 32-bit registers, two asynchronous read ports addressed by rs and rt.
- One synchronous write port. Its destination is rs or rt, chosen by a 2-bit write-select code.
- Sits between instruction decode (supplies rs/rt) and the ALU/writeback path (consumes reg_val1/reg_val2, supplies write_data).

Parameters:
- DATA_W, 32, width of each register and of the data ports
- ADDR_W, 6, width of rs/rt. Register count is 2**ADDR_W = 64.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  reset, synchronous, active-high; clears every register
- rs  input  ADDR_W  read address for port 1; also write address when reg_write=01
- rt  input  ADDR_W  read address for port 2; also write address when reg_write=10
- reg_write  input  2  write select: 00 none, 01 write reg[rs], 10 write reg[rt], 11 none (reserved)
- write_data  input  DATA_W  data written on a qualifying rising edge
- reg_val1  output  DATA_W  contents of reg[rs], combinational
- reg_val2  output  DATA_W  contents of reg[rt], combinational

Behaviour:
- Storage: 64 registers of DATA_W bits, indices 0..63. No hardwired-zero register; register 0 is writable like any other.
- Reset:
  - On a rising clk edge with rst=1, all 64 registers become 0.
  - Reset has priority over any write in the same cycle.
  - rst is sampled only at clk edges; asserting it between edges has no effect until the next edge.
  - Consequently reg_val1 = reg_val2 = 0 after the first reset edge.
  - Before the first reset edge, contents are undefined (X in simulation).
- Read:
  - reg_val1 = reg[rs] and reg_val2 = reg[rt], purely combinational, zero-cycle latency.
  - Outputs follow address changes immediately, with no clock needed.
  - rs == rt is legal; both outputs then show the same value.
- Write:
  - On a rising clk edge with rst=0:
    - reg_write=01: reg[rs] <= write_data
    - reg_write=10: reg[rt] <= write_data
    - 00 or 11: no register changes
  - At most one register is written per cycle.
  - Address, select and data are sampled at the edge.
- Read-during-write:
  - Before the edge, the read ports show the old value.
  - After the edge, the read ports show the new value in the same cycle the edge completes.
  - There is no internal bypass of write_data to the outputs.
- Address 63 and address 0 behave identically to all others; there is no wrap-around or out-of-range case, since the 6-bit address covers all 64 entries.
- Reset mid-operation: a pending write is discarded and all registers are cleared.

Test Plan:
- Reset: hold rst=1 for 25 clk cycles, rs=rt=0 -> reg_val1=reg_val2=0. Sweeping rs/rt over 0..63 with reg_write=00 reads 0 everywhere.
- Write via rs: rst=0, rs=1, reg_write=01, write_data=16, one edge -> reg_val1=16. Setting rt=1 gives reg_val2=16 with no further edge.
- Write via rt, then hold:
  - rt=2, reg_write=10, write_data=22, one edge -> reg_val2=22, reg[1] still 16.
  - Then rs=1, rt=2, reg_write=00, write_data=10 over several edges -> reg_val1=16, reg_val2=22, unchanged.
- Overwrite and reserved code:
  - rs=1, reg_write=01, write_data=9, one edge -> reg_val1=9.
  - Then reg_write=11, write_data=77 for one edge -> reg[rs] and reg[rt] unchanged.
- Same-cycle conflicts:
  - rst=1 together with reg_write=01, rs=5, write_data=0xFFFFFFFF -> after the edge, reg[5]=0.
  - Write 0xDEADBEEF to reg[63] via rt, rs=rt=63 -> both outputs 0xDEADBEEF; reg[0] remains independently writable.

Source files
------------

// File: rtl/reg_file.sv
// General-purpose register file: 64 x DATA_W storage, two combinational read
// ports addressed by rs/rt, one synchronous write port targeting rs or rt.
module reg_file #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [1:0]        reg_write,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] reg_val1,
    output logic [DATA_W-1:0] reg_val2
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        WSEL_NONE = 2'b00,
        WSEL_RS   = 2'b01,
        WSEL_RT   = 2'b10,
        WSEL_RSVD = 2'b11
    } wsel_t;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;

    // Decode the write-select code into a single enable and destination.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = rs;
        case (wsel_t'(reg_write))
            WSEL_RS: begin
                wr_en   = 1'b1;
                wr_addr = rs;
            end
            WSEL_RT: begin
                wr_en   = 1'b1;
                wr_addr = rt;
            end
            default: begin
                wr_en   = 1'b0;
                wr_addr = rs;
            end
        endcase
    end

    // Reset clears every entry and takes priority over a same-edge write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= write_data;
        end
    end

    assign reg_val1 = regs[rs];
    assign reg_val2 = regs[rt];

endmodule

// File: tb/tb_reg_file.sv
// Directed plus randomized checks of reg_file reads, writes, select codes and
// reset priority, using a reference array and an expected-value queue.
module tb_reg_file;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned NREG   = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [ADDR_W-1:0] rs = '0;
    logic [ADDR_W-1:0] rt = '0;
    logic [1:0]        reg_write = 2'b00;
    logic [DATA_W-1:0] write_data = '0;
    logic [DATA_W-1:0] reg_val1;
    logic [DATA_W-1:0] reg_val2;

    typedef struct {
        string             tag;
        logic [DATA_W-1:0] e1;
        logic [DATA_W-1:0] e2;
    } exp_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] model [NREG];
    int                n_checks = 0;
    int                n_fail   = 0;

    reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .rs         (rs),
        .rt         (rt),
        .reg_write  (reg_write),
        .write_data (write_data),
        .reg_val1   (reg_val1),
        .reg_val2   (reg_val2)
    );

    always #5 clk = ~clk;

    // Apply the current inputs to the reference array, then take one edge.
    task automatic tick();
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) model[i] = '0;
        end else if (reg_write == 2'b01) begin
            model[rs] = write_data;
        end else if (reg_write == 2'b10) begin
            model[rt] = write_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic compare_out();
        exp_t e;
        e = sb.pop_front();
        n_checks++;
        assert (reg_val1 === e.e1) else begin
            n_fail++;
            $error("FAIL %s reg_val1 observed=%h expected=%h", e.tag, reg_val1, e.e1);
        end
        n_checks++;
        assert (reg_val2 === e.e2) else begin
            n_fail++;
            $error("FAIL %s reg_val2 observed=%h expected=%h", e.tag, reg_val2, e.e2);
        end
    endtask

    task automatic expect_vals(input string tag, input logic [DATA_W-1:0] e1,
                               input logic [DATA_W-1:0] e2);
        exp_t e;
        e.tag = tag;
        e.e1  = e1;
        e.e2  = e2;
        sb.push_back(e);
        #1;
        compare_out();
    endtask

    task automatic expect_model(input string tag);
        expect_vals(tag, model[rs], model[rt]);
    endtask

    initial begin
        for (int i = 0; i < int'(NREG); i++) model[i] = 'x;

        // Long reset, then a read sweep with no writes.
        rst = 1'b1;
        repeat (25) tick();
        expect_vals("reset", 32'd0, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < int'(NREG); i++) begin
            rs = ADDR_W'(i);
            rt = ADDR_W'(NREG - 1 - i);
            tick();
            expect_vals("sweep_zero", 32'd0, 32'd0);
        end

        rs = 6'd1; rt = 6'd0; reg_write = 2'b01; write_data = 32'd16;
        tick();
        reg_write = 2'b00;
        expect_vals("write_rs", 32'd16, 32'd0);
        rt = 6'd1;
        expect_vals("read_rt_no_edge", 32'd16, 32'd16);

        rs = 6'd1; rt = 6'd2; reg_write = 2'b10; write_data = 32'd22;
        tick();
        expect_vals("write_rt", 32'd16, 32'd22);
        reg_write = 2'b00; write_data = 32'd10;
        repeat (3) tick();
        expect_vals("hold_00", 32'd16, 32'd22);

        reg_write = 2'b01; write_data = 32'd9;
        tick();
        expect_vals("overwrite", 32'd9, 32'd22);
        reg_write = 2'b11; write_data = 32'd77;
        tick();
        expect_vals("reserved_11", 32'd9, 32'd22);

        reg_write = 2'b01; write_data = 32'd55;
        expect_vals("rdw_before_edge", 32'd9, 32'd22);
        tick();
        expect_vals("rdw_after_edge", 32'd55, 32'd22);

        rs = 6'd5; reg_write = 2'b01; write_data = 32'h0000_1234;
        tick();
        expect_vals("write_r5", 32'h0000_1234, 32'd22);
        rst = 1'b1; write_data = 32'hFFFF_FFFF;
        tick();
        rst = 1'b0; reg_write = 2'b00;
        expect_vals("reset_beats_write", 32'd0, 32'd0);

        rt = 6'd63; reg_write = 2'b10; write_data = 32'hDEAD_BEEF;
        tick();
        rs = 6'd63; reg_write = 2'b00;
        expect_vals("r63_both_ports", 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        rs = 6'd0; reg_write = 2'b01; write_data = 32'h0000_A5A5;
        tick();
        reg_write = 2'b00;
        expect_vals("r0_writable", 32'h0000_A5A5, 32'hDEAD_BEEF);

        // A reset pulse that falls between edges must have no effect.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
        expect_vals("rst_between_edges", 32'h0000_A5A5, 32'hDEAD_BEEF);

        for (int n = 0; n < 400; n++) begin
            rs         = ADDR_W'($urandom_range(0, NREG - 1));
            rt         = ADDR_W'($urandom_range(0, NREG - 1));
            reg_write  = 2'($urandom_range(0, 3));
            write_data = $urandom;
            rst        = ($urandom_range(0, 79) == 0);
            expect_model("random_pre_edge");
            tick();
            rst = 1'b0;
            reg_write = 2'b00;
            expect_model("random_post_edge");
            rs = ADDR_W'($urandom_range(0, NREG - 1));
            expect_model("random_read");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
